bytecode_fetch: RTL and testbench

- Upstream neighbour of the bytecode decoder.
- Reads the byte-wide bytecode memory through a small prefetch buffer and assembles each instruction (opcode byte plus optional 8-bit operand) into the 16-bit word the decoder consumes.
- Hands each word to the decoder with a start/ready handshake and holds it stable while the decoder runs.
- Supports a PC redirect that flushes all prefetched state.

---
 rtl/jvm_fetch_pkg.sv | 25 ++
 rtl/bytecode_fetch_byte_fifo.sv | 49 ++++
 rtl/bytecode_fetch.sv | 143 ++++++++++++++
 tb/tb_bytecode_fetch.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/jvm_fetch_pkg.sv
// Shared types and opcode-length decode for the bytecode fetch unit.
package jvm_fetch_pkg;
  localparam int BYTE_W     = 8;
  localparam int WIDTH_OUT  = 2 * BYTE_W;
  localparam int ADDR_W     = 16;
  localparam int FIFO_DEPTH = 4;

  typedef enum logic [2:0] {GET_OP, GET_ARG, PRESENT, BUSY, DRAIN} asm_state_e;

  localparam logic [7:0] BIPUSH   = 8'h10;
  localparam logic [7:0] LDC      = 8'h12;
  localparam logic [7:0] NEWARRAY = 8'hBC;
  localparam logic [7:0] LOAD_LO  = 8'h15;
  localparam logic [7:0] LOAD_HI  = 8'h19;
  localparam logic [7:0] STORE_LO = 8'h36;
  localparam logic [7:0] STORE_HI = 8'h3A;

  // Undefined opcodes are single-byte; the decoder's default arm deals with them.
  function automatic logic [1:0] op_len(input logic [7:0] op);
    if (op == BIPUSH || op == LDC || op == NEWARRAY ||
        (op >= LOAD_LO && op <= LOAD_HI) || (op >= STORE_LO && op <= STORE_HI))
      return 2'd2;
    return 2'd1;
  endfunction
endpackage

// File: rtl/bytecode_fetch_byte_fifo.sv
// Small power-of-two FIFO with flush; push and pop may coincide.
module byte_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rd_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !reset && !flush_i) mem_q[wr_q] <= din_i;
  end
endmodule

// File: rtl/bytecode_fetch.sv
// Prefetches bytecode bytes, assembles {opcode,operand} words and hands them
// to the decoder with a start/ready handshake.
module bytecode_fetch
  import jvm_fetch_pkg::*;
#(
  parameter int BYTE_W_P     = BYTE_W,
  parameter int WIDTH_OUT_P  = WIDTH_OUT,
  parameter int ADDR_W_P     = ADDR_W,
  parameter int FIFO_DEPTH_P = FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  input  logic                   pc_load,
  input  logic [ADDR_W_P-1:0]    pc_load_value,
  output logic                   mem_req,
  output logic [ADDR_W_P-1:0]    mem_addr,
  input  logic                   mem_ack,
  input  logic [BYTE_W_P-1:0]    mem_data,
  output logic                   start_for_decoder,
  input  logic                   decoder_ready,
  output logic [WIDTH_OUT_P-1:0] instruction_out,
  output logic [ADDR_W_P-1:0]    pc
);
  localparam int CW = $clog2(FIFO_DEPTH_P) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH_P);

  logic                   req_q, req_d;
  logic [ADDR_W_P-1:0]    fptr_q, fptr_d;
  asm_state_e             state_q, state_d;
  logic [BYTE_W_P-1:0]    op_q, op_d;
  logic [ADDR_W_P-1:0]    oppc_q, oppc_d, pc_q, pc_d, rd_addr;
  logic [WIDTH_OUT_P-1:0] instr_q, instr_d;
  logic                   start_q, start_d;
  logic                   push, pop, fifo_full, fifo_empty;
  logic [BYTE_W_P-1:0]    fifo_dout;
  logic [CW-1:0]          fifo_cnt;

  // Acks arriving with a redirect, or with nothing outstanding, are dropped.
  assign push = mem_ack && req_q && !pc_load && !fifo_full;

  byte_fifo #(.DEPTH(FIFO_DEPTH_P), .WIDTH(BYTE_W_P)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush_i (pc_load),
    .push_i  (push),
    .din_i   (mem_data),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  // The FIFO holds a contiguous run ending just below the fetch pointer,
  // so the head byte's address falls out of the count.
  assign rd_addr = fptr_q - ADDR_W_P'(fifo_cnt);

  always_comb begin
    fptr_d = fptr_q;
    req_d  = req_q;
    if (pc_load) begin
      fptr_d = pc_load_value;
      req_d  = 1'b0;
    end else if (req_q) begin
      if (mem_ack) begin
        fptr_d = fptr_q + ADDR_W_P'(1);
        req_d  = 1'b0;
      end
    end else begin
      req_d = run && (fifo_cnt < DEPTH_C);
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    oppc_d  = oppc_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    start_d = 1'b0;
    pop     = 1'b0;
    case (state_q)
      GET_OP: if (!pc_load && !fifo_empty) begin
        pop    = 1'b1;
        op_d   = fifo_dout;
        oppc_d = rd_addr;
        if (op_len(fifo_dout) == 2'd2) begin
          state_d = GET_ARG;
        end else begin
          instr_d = {fifo_dout, {BYTE_W_P{1'b0}}};
          pc_d    = rd_addr;
          state_d = PRESENT;
        end
      end
      GET_ARG: if (pc_load) begin
        state_d = GET_OP;
      end else if (!fifo_empty) begin
        pop     = 1'b1;
        instr_d = {op_q, fifo_dout};
        pc_d    = oppc_q;
        state_d = PRESENT;
      end
      PRESENT: if (pc_load) begin
        state_d = GET_OP;
      end else if (decoder_ready) begin
        start_d = 1'b1;
        state_d = BUSY;
      end
      BUSY:    if (!decoder_ready) state_d = DRAIN;
      DRAIN:   if (decoder_ready) state_d = GET_OP;
      default: state_d = GET_OP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_q   <= 1'b0;
      fptr_q  <= '0;
      state_q <= GET_OP;
      op_q    <= '0;
      oppc_q  <= '0;
      instr_q <= '0;
      pc_q    <= '0;
      start_q <= 1'b0;
    end else begin
      req_q   <= req_d;
      fptr_q  <= fptr_d;
      state_q <= state_d;
      op_q    <= op_d;
      oppc_q  <= oppc_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      start_q <= start_d;
    end
  end

  assign mem_req           = req_q;
  assign mem_addr          = fptr_q;
  assign start_for_decoder = start_q;
  assign instruction_out   = instr_q;
  assign pc                = pc_q;
endmodule

// File: tb/tb_bytecode_fetch.sv
// Random bytecode memory, behavioural decoder and program-order reference model.
module tb_bytecode_fetch;
  logic        clk = 1'b0;
  logic        reset, run, pc_load, mem_req, mem_ack, start_for_decoder, decoder_ready;
  logic [15:0] pc_load_value, mem_addr, instruction_out, pc;
  logic [7:0]  mem_data;

  always #5 clk = ~clk;

  bytecode_fetch dut (
    .clk(clk), .reset(reset), .run(run), .pc_load(pc_load), .pc_load_value(pc_load_value),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .start_for_decoder(start_for_decoder), .decoder_ready(decoder_ready),
    .instruction_out(instruction_out), .pc(pc)
  );

  logic [7:0]  mem [65536];
  int          checks = 0, errors = 0;
  logic [15:0] exp_pc, exp_faddr, hold_instr, hold_pc, held_addr, redir_val;
  logic [15:0] log_instr[$], log_pc[$];
  bit          hs, prev_req, last_ack, last_pcload, run_e, reset_e, redir_req, redir_on_ack;
  int          dec_cnt, ack_wait, stall_next, redir_idx;

  function automatic int blen(input logic [7:0] op);
    if (op inside {8'h10, 8'h12, 8'hBC, [8'h15:8'h19], [8'h36:8'h3A]}) return 2;
    return 1;
  endfunction

  function automatic logic [15:0] exp_word(input logic [15:0] a);
    logic [15:0] a1;
    a1 = a + 16'd1;
    return {mem[a], (blen(mem[a]) == 2) ? mem[a1] : 8'h00};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    run_e   = run;
    reset_e = reset;
    @(negedge clk);
    pc_load = 1'b0;
    mem_ack = 1'b0;
    if (reset_e) begin
      exp_pc = 16'h0; exp_faddr = 16'h0; hs = 0; decoder_ready = 1'b1;
      prev_req = 0; last_ack = 0; last_pcload = 0; ack_wait = 0;
      return;
    end
    // decoder side: every start must carry the next instruction in program order
    if (start_for_decoder) begin
      chk("start_while_busy", 32'(hs), 32'd0);
      chk("instr_at_start", 32'(instruction_out), 32'(exp_word(exp_pc)));
      chk("pc_at_start", 32'(pc), 32'(exp_pc));
      log_instr.push_back(instruction_out);
      log_pc.push_back(pc);
      hold_instr = instruction_out;
      hold_pc    = pc;
      exp_pc     = exp_pc + 16'(blen(mem[exp_pc]));
      hs = 1; decoder_ready = 1'b0;
      dec_cnt = (stall_next > 0) ? stall_next : $urandom_range(1, 4);
      stall_next = 0;
    end else if (hs) begin
      chk("hold_instr", 32'(instruction_out), 32'(hold_instr));
      chk("hold_pc", 32'(pc), 32'(hold_pc));
      if (dec_cnt > 0) dec_cnt--;
      else begin decoder_ready = 1'b1; hs = 0; end
    end
    // memory side
    if (last_ack || last_pcload) chk("req_drop", 32'(mem_req), 32'd0);
    else if (mem_req && prev_req) chk("addr_stable", 32'(mem_addr), 32'(held_addr));
    if (mem_req && !prev_req) begin
      chk("issue_run", 32'(run_e), 32'd1);
      chk("issue_addr", 32'(mem_addr), 32'(exp_faddr));
      held_addr = mem_addr;
      ack_wait  = $urandom_range(0, 2);
    end
    last_ack = 0;
    if (mem_req) begin
      if (ack_wait == 0) begin
        mem_ack = 1'b1; mem_data = mem[mem_addr];
        exp_faddr = exp_faddr + 16'd1; last_ack = 1;
        if (redir_on_ack) begin redir_req = 1; redir_on_ack = 0; end
      end else ack_wait--;
    end else if (last_pcload) begin
      mem_ack = 1'($urandom_range(0, 1)); mem_data = 8'($urandom);
    end
    last_pcload = 0;
    if (redir_req) begin
      pc_load = 1'b1; pc_load_value = redir_val;
      exp_pc = redir_val; exp_faddr = redir_val;
      redir_idx = log_instr.size(); redir_req = 0; last_pcload = 1;
    end
    prev_req = mem_req;
  endtask

  task automatic wait_starts(input int n, input int budget, input string name);
    int target = log_instr.size() + n;
    int b = 0;
    while (log_instr.size() < target && b < budget) begin step(); b++; end
    if (log_instr.size() < target) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_redirect_start(input int budget, input string name);
    int b = 0;
    while ((redir_on_ack || redir_req || log_instr.size() <= redir_idx) && b < budget) begin
      step(); b++;
    end
    if (log_instr.size() <= redir_idx) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    logic [7:0] tbl [12] = '{8'h10, 8'h12, 8'h15, 8'h19, 8'h36, 8'h3A, 8'hBC,
                             8'h60, 8'h00, 8'h14, 8'h3B, 8'hFF};
    for (int i = 0; i < 65536; i++)
      mem[i] = ($urandom_range(0, 1) == 1) ? tbl[$urandom_range(0, 11)] : 8'($urandom);
    mem[0] = 8'h60; mem[1] = 8'h10; mem[2] = 8'h2A; mem[3] = 8'h00;
    mem[16'h0100] = 8'hBC; mem[16'h0101] = 8'h05; mem[16'hFFFF] = 8'h10;
    reset = 1'b1; run = 1'b0; pc_load = 1'b0; pc_load_value = 16'h0;
    mem_ack = 1'b0; mem_data = 8'h0; decoder_ready = 1'b1;
    stall_next = 0; redir_req = 0; redir_on_ack = 0; redir_idx = 0;
    redir_val = 16'h0; hold_instr = 16'h0; hold_pc = 16'h0; held_addr = 16'h0;
    repeat (3) step();
    reset = 1'b0;
    step();
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_start", 32'(start_for_decoder), 32'd0);
    chk("rst_instr", 32'(instruction_out), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);

    run = 1'b1;
    wait_starts(3, 300, "first_three");
    if (log_instr.size() >= 3) begin
      chk("lit_iadd", 32'(log_instr[0]), 32'h6000);
      chk("lit_iadd_pc", 32'(log_pc[0]), 32'h0);
      chk("lit_bipush", 32'(log_instr[1]), 32'h102A);
      chk("lit_bipush_pc", 32'(log_pc[1]), 32'h1);
      chk("lit_nop_pc", 32'(log_pc[2]), 32'h3);
    end

    // decoder stalls long enough for the prefetch buffer to fill
    stall_next = 40;
    wait_starts(1, 300, "stall_start");
    repeat (25) step();
    chk("full_no_req", 32'(mem_req), 32'd0);
    chk("full_fptr", 32'(mem_addr), 32'(exp_pc + 16'd4));
    for (int b = 0; b < 100 && hs; b++) step();

    redir_val = 16'h0100; redir_on_ack = 1;
    wait_redirect_start(300, "redir_ack");
    if (log_instr.size() > redir_idx) begin
      chk("lit_newarray", 32'(log_instr[redir_idx]), 32'hBC05);
      chk("lit_newarray_pc", 32'(log_pc[redir_idx]), 32'h0100);
    end

    redir_val = 16'hFFFF; redir_req = 1;
    wait_redirect_start(300, "redir_wrap");
    wait_starts(1, 300, "wrap_next");
    if (log_instr.size() > redir_idx + 1) begin
      chk("lit_wrap_instr", 32'(log_instr[redir_idx]), 32'h1060);
      chk("lit_wrap_pc", 32'(log_pc[redir_idx]), 32'hFFFF);
      chk("lit_after_wrap_pc", 32'(log_pc[redir_idx + 1]), 32'h0001);
    end

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) run = ($urandom_range(0, 3) != 0);
      if (!redir_req && !redir_on_ack && $urandom_range(0, 199) == 0) begin
        redir_val = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'hFFF0 + 16'($urandom_range(0, 15));
        if ($urandom_range(0, 1) == 1) redir_on_ack = 1; else redir_req = 1;
      end
      if ($urandom_range(0, 299) == 0) stall_next = 30;
      step();
    end
    run = 1'b1; redir_on_ack = 0;
    wait_starts(3, 600, "final_progress");

    // reset mid-operation, then an ack with nothing outstanding
    run = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0;
    mem_ack = 1'b1; mem_data = 8'h55;
    step();
    chk("rst2_mem_req", 32'(mem_req), 32'd0);
    chk("rst2_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst2_instr", 32'(instruction_out), 32'd0);
    chk("rst2_pc", 32'(pc), 32'd0);
    chk("rst2_start", 32'(start_for_decoder), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
